rr_arbiter_8: RTL
=================

# rr_arbiter_8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. Its registered one-hot grant is the decode of a 3-bit owner index, so the same index can steer 3-to-8 select logic. Fairness comes from rotating priority and a bounded grant tenure. It sits between the requesting units and the shared resource.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one grant may last. Legal range 1..256.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  arbitration enable. When low, no new grant is issued; a grant in progress continues.
- req  input  8  request vector; bit i is requester i. A requester holds its bit high while it wants or uses the resource.
- gnt  output  8  one-hot grant, registered. All zero when idle.
- gnt_idx  output  3  binary index of the owner, registered. Holds the last owner while idle.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.

## Operation
- Reset (async assert, leave on clk edge after deassert):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, hold counter=0.
  - last-owner pointer=7, so requester 0 has top priority at first arbitration.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, pick the winner: the first set req bit scanning last+1, last+2, ... mod 8.
  - Next edge: state=GRANT, gnt_idx=winner, gnt=1<<winner, gnt_valid=1, counter=0.
  - Otherwise stay IDLE with gnt=0.
- GRANT:
  - Each cycle the counter increments.
  - Release condition: req[gnt_idx]=0, or counter==MAX_HOLD-1.
  - On release, next edge: state=IDLE, gnt=0, gnt_valid=0, last=gnt_idx. gnt_idx keeps its value.
  - Otherwise hold the grant unchanged.
- Other requesters' req bits, and en, have no effect during GRANT.
- Timeout: the expired owner becomes lowest priority. If it is still requesting, it is re-granted only after every other active requester has been considered.
- Counter width is clog2(MAX_HOLD), minimum 1 bit. It never wraps during a grant, because release happens at MAX_HOLD-1.
- gnt is always exactly zero or one-hot. gnt==(1<<gnt_idx) whenever gnt_valid=1.

## Timing
- Latency from req rising in IDLE (en=1) to gnt: 1 clk edge.
- Grant duration:
  - Owner drops req in cycle k (counting the first grant cycle as 0): gnt is high for cycles 0..k and low from k+1.
  - Owner holds req continuously: gnt lasts exactly MAX_HOLD cycles.
- Turnaround: at least one IDLE cycle with gnt=0 between consecutive grants, including a re-grant to the same requester.
- Back-to-back throughput with all requesters active: one grant of MAX_HOLD cycles every MAX_HOLD+1 cycles.
- MAX_HOLD=1: every grant lasts 1 cycle, alternating with 1 idle cycle.
- req changes in the same cycle as the release edge: ignored until IDLE evaluates in the following cycle.
- en deasserted mid-grant: the grant completes normally; then the arbiter stays IDLE until en=1.
- rst asserted mid-grant: gnt, gnt_idx and gnt_valid clear immediately (asynchronously), with no clock needed. The pointer returns to 7.
- All outputs come straight from flops; there is no combinational path from req to gnt.

## Test plan
- Reset priority: release rst, then drive req=8'b1000_0001 held. Required: first grant gnt=8'h01, gnt_idx=0 after 1 edge. After timeout and 1 idle cycle, gnt=8'h80.
- Rotation: req=8'hFF held, MAX_HOLD=4. Required: grant order 0,1,...,7,0. Each grant 4 cycles, with 1 idle cycle between grants.
- Early release: requester 3 alone, req[3] dropped in grant cycle 2 (MAX_HOLD=16). Required: gnt=8'h08 for 3 cycles, then 0; gnt_idx stays 3.
- Timeout fairness: req[5] held, req[2] asserted mid-grant, MAX_HOLD=8. Required: requester 5 released after 8 cycles, then 1 idle cycle, then gnt=8'h04.
- Enable gating: en=0 with req=8'h10. Required: no grant. Set en=1; required: gnt=8'h10 on the next edge. Dropping en mid-grant must not shorten the grant.
- Async reset mid-grant: assert rst between clock edges while gnt=8'h20. Required: gnt=0, gnt_valid=0, gnt_idx=0 before the next edge. After release with req=8'hFF, the first grant goes to 0.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants.
interface rr_arbiter_8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded grant tenure.
// The grant is the registered decode of a 3-bit owner index. Priority
// rotates from the slot after the last owner, so a timed-out owner that
// keeps requesting is only reconsidered after every other requester.

// One rotated-priority lane: lane k reports the request of the requester
// sitting k+1 slots after the last owner. Lane 0 is therefore the highest
// priority candidate.
module rr_arbiter_8_lane #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3,
    parameter int LANE    = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               rot_req
);
    logic [IDX_W-1:0] sel;

    // NUM_REQ is a power of two, so index arithmetic wraps naturally.
    assign sel     = last + IDX_W'(LANE + 1);
    assign rot_req = req[sel];
endmodule

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  bus
);
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [IDX_W-1:0]   last_q,      last_d;

    logic [NUM_REQ-1:0] rot_req;
    logic [IDX_W-1:0]   win_off;
    logic [IDX_W-1:0]   winner;
    logic               release_grant;

    // Rotate the request vector so that bit 0 is the slot after the last owner.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        rr_arbiter_8_lane #(
            .NUM_REQ (NUM_REQ),
            .IDX_W   (IDX_W),
            .LANE    (k)
        ) u_lane (
            .req     (bus.req),
            .last    (last_q),
            .rot_req (rot_req[k])
        );
    end

    // Lowest set bit of the rotated vector is the winner's distance past last+1.
    always_comb begin
        win_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) win_off = IDX_W'(k);
        end
        winner = last_q + win_off + IDX_W'(1);
    end

    // Owner released when it stops requesting or its tenure reaches the limit.
    always_comb begin
        release_grant = !bus.req[gnt_idx_q] || (cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic for the two-state grant machine.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        cnt_d       = cnt_q;
        last_d      = last_q;

        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
                if (bus.en && (bus.req != '0)) begin
                    state_d     = GRANT;
                    gnt_idx_d   = winner;
                    gnt_d       = NUM_REQ'(1) << winner;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                // en and other requesters are deliberately ignored here.
                if (release_grant) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    last_d      = gnt_idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            cnt_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
endmodule
